packet_buffer_ctrl: RTL and testbench

//  Store-and-forward packet buffer sequencer around an external simple dual-port block RAM.
//  The RAM has a 1-cycle registered read and words of WIDTH+1 bits; bit WIDTH holds the last flag.
//  - Ingress: line-rate packet stream with no backpressure. A packet is released to egress only after its last word is written.
//  - Overflowing packets are dropped whole.
//  - Egress: valid/ready stream. Sits between SRv6 header rewrite stages.

---
 rtl/packet_buffer_ctrl_pkg.sv | 17 +
 rtl/packet_buffer_ctrl_if.sv | 13 +
 rtl/packet_buffer_ctrl_skid.sv | 55 +++++
 rtl/packet_buffer_ctrl.sv | 122 ++++++++++++
 tb/tb_packet_buffer_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/packet_buffer_ctrl_pkg.sv
// Shared types for the SRv6 packet buffer sequencer.
//   wr_state_t : ingress write FSM states
//   ptr_width  : pointer width for a RAM of 2**depth words (one extra wrap bit)
package srv6_pkg;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_RECV = 2'd1,
    WR_DROP = 2'd2
  } wr_state_t;

  // The extra MSB distinguishes a full buffer from an empty one.
  function automatic int ptr_width(input int depth);
    return depth + 1;
  endfunction

endpackage

// File: rtl/packet_buffer_ctrl_if.sv
// Packet word stream: valid/ready handshake carrying a data word and an
// end-of-packet flag.
//   master : drives valid/data/last, samples ready
//   slave  : samples valid/data/last, drives ready
interface packet_buffer_ctrl_if #(parameter int WIDTH = 32);
  logic             valid;
  logic             ready;
  logic             last;
  logic [WIDTH-1:0] data;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/packet_buffer_ctrl_skid.sv
// Two-entry register FIFO between the RAM read port and the egress stream.
//   push/din   : word returned by the RAM this cycle
//   pop        : egress ready; a word leaves when valid && pop
//   valid/dout : head of the FIFO; when empty the incoming word is shown
//                directly so a freshly read word reaches egress without an
//                extra register stage
//   count      : stored entries (0..2); the caller never pushes into a full FIFO
module pkt_out_skid #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] e0, e1;
  logic         take;

  assign valid = (count != 2'd0) || push;
  assign dout  = (count != 2'd0) ? e0 : din;
  assign take  = pop && valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 2'd0;
      e0    <= '0;
      e1    <= '0;
    end else begin
      case ({push, take})
        2'b10: begin
          if (count == 2'd0) e0 <= din;
          else               e1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Empty: the word bypasses straight out, nothing to store.
          if (count == 2'd1) e0 <= din;
          else if (count == 2'd2) begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/packet_buffer_ctrl.sv
// Store-and-forward packet buffer sequencer for an external simple dual-port
// RAM (1-cycle registered read, WIDTH+1 bit words, MSB = last flag).
//   clk, reset_n        : clock, asynchronous active-low reset
//   ingress (slave)     : line-rate word stream, always accepted (ready tied 1)
//   egress (master)     : valid/ready word stream of committed packets
//   ram_waddress/din/we : RAM write port
//   ram_raddress/dout   : RAM read port, dout valid one cycle after address
//   pkt_count           : committed packets not yet fully read out
//   drop_count          : saturating count of dropped packets
//   drop_pulse          : one-cycle pulse per drop decision
module packet_buffer_ctrl
  import srv6_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 10,
  parameter int WORDS = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  packet_buffer_ctrl_if.slave  ingress,
  packet_buffer_ctrl_if.master egress,
  output logic [31:0]         ram_waddress,
  output logic [WIDTH:0]      ram_din,
  output logic                ram_we,
  output logic [31:0]         ram_raddress,
  input  logic [WIDTH:0]      ram_dout,
  output logic [15:0]         pkt_count,
  output logic [31:0]         drop_count,
  output logic                drop_pulse
);
  localparam int PTR_W = ptr_width(DEPTH);

  wr_state_t        state;
  logic [PTR_W-1:0] wr_ptr, commit_ptr, rd_ptr, used;
  logic             full, wr_ok, commit, rd_issue, ret_vld, pop_last;
  logic [1:0]       skid_cnt;
  logic [WIDTH:0]   head;
  logic             skid_vld;

  assign used  = wr_ptr - rd_ptr;
  assign full  = (used == PTR_W'(WORDS));
  assign wr_ok = ingress.valid && !full && (state != WR_DROP);

  assign ingress.ready = 1'b1;
  assign ram_we        = wr_ok;
  assign ram_din       = {ingress.last, ingress.data};
  assign ram_waddress  = 32'(wr_ptr[DEPTH-1:0]);
  assign commit        = wr_ok && ingress.last;

  // Write FSM. A full buffer on any word of the current packet rewinds the
  // write pointer to the last commit point, discarding the partial packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= WR_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      drop_count <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      if (ingress.valid) begin
        case (state)
          WR_IDLE, WR_RECV: begin
            if (!full) begin
              wr_ptr <= wr_ptr + 1'b1;
              if (ingress.last) begin
                commit_ptr <= wr_ptr + 1'b1;
                state      <= WR_IDLE;
              end else begin
                state <= WR_RECV;
              end
            end else begin
              wr_ptr     <= commit_ptr;
              drop_pulse <= 1'b1;
              if (drop_count != '1) drop_count <= drop_count + 32'd1;
              state <= ingress.last ? WR_IDLE : WR_DROP;
            end
          end
          WR_DROP: if (ingress.last) state <= WR_IDLE;
          default: state <= WR_IDLE;
        endcase
      end
    end
  end

  // Reads only cover committed words. Stored skid entries plus the read in
  // flight never exceed the two skid slots, so the skid cannot overflow.
  assign rd_issue     = (rd_ptr != commit_ptr) && ((3'(skid_cnt) + 3'(ret_vld)) < 3'd2);
  assign ram_raddress = 32'(rd_ptr[DEPTH-1:0]);
  assign pop_last     = skid_vld && egress.ready && head[WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr    <= '0;
      ret_vld   <= 1'b0;
      pkt_count <= '0;
    end else begin
      ret_vld <= rd_issue;
      if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
      case ({commit, pop_last})
        2'b10:   pkt_count <= pkt_count + 16'd1;
        2'b01:   pkt_count <= pkt_count - 16'd1;
        default: ;
      endcase
    end
  end

  pkt_out_skid #(.W(WIDTH + 1)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (ret_vld),
    .din     (ram_dout),
    .pop     (egress.ready),
    .valid   (skid_vld),
    .dout    (head),
    .count   (skid_cnt)
  );

  assign egress.valid = skid_vld;
  assign egress.data  = head[WIDTH-1:0];
  assign egress.last  = head[WIDTH];
endmodule

// File: tb/tb_packet_buffer_ctrl.sv
// Self-checking bench for packet_buffer_ctrl with a 16-word RAM model.
// Expected egress traffic is a queue of committed packet words; drop
// decisions come from the free-space rule (RAM-resident words vs capacity).
module tb_packet_buffer_ctrl;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int WORDS = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  packet_buffer_ctrl_if #(.WIDTH(WIDTH)) ingress ();
  packet_buffer_ctrl_if #(.WIDTH(WIDTH)) egress ();

  logic [31:0]    ram_waddress, ram_raddress, drop_count;
  logic [WIDTH:0] ram_din, ram_dout;
  logic           ram_we, drop_pulse;
  logic [15:0]    pkt_count;
  logic [WIDTH:0] mem [WORDS];

  always @(posedge clk) begin
    if (ram_we) mem[ram_waddress[DEPTH-1:0]] <= ram_din;
    ram_dout <= mem[ram_raddress[DEPTH-1:0]];
  end

  packet_buffer_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WORDS(WORDS)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ingress      (ingress),
    .egress       (egress),
    .ram_waddress (ram_waddress),
    .ram_din      (ram_din),
    .ram_we       (ram_we),
    .ram_raddress (ram_raddress),
    .ram_dout     (ram_dout),
    .pkt_count    (pkt_count),
    .drop_count   (drop_count),
    .drop_pulse   (drop_pulse)
  );

  int             checks = 0;
  int             errs = 0;
  logic [WIDTH:0] exp_q[$];
  int             rd_idx = 0;
  int             wa_commit = 0;
  int             drops = 0;
  bit             prev_stall = 0;
  logic [WIDTH:0] prev_word;
  bit             rnd_rdy = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic int pend_pkts();
    int n = 0;
    for (int i = rd_idx; i < exp_q.size(); i++) if (exp_q[i][WIDTH]) n++;
    return n;
  endfunction

  // One clock: egress scoreboard at the falling edge, then new ready value
  // just after the rising edge.
  task automatic cyc();
    @(negedge clk);
    if (!reset_n) begin
      rd_idx     = exp_q.size();
      prev_stall = 0;
    end else begin
      if (prev_stall)
        chk("stall_hold", 64'({egress.valid, egress.last, egress.data}), 64'({1'b1, prev_word}));
      if (egress.valid && egress.ready) begin
        if (rd_idx < exp_q.size()) begin
          chk("egress_word", 64'({egress.last, egress.data}), 64'(exp_q[rd_idx]));
          rd_idx++;
        end else begin
          chk("spurious_valid", 64'(egress.valid), 64'(1'b0));
        end
      end
      prev_stall = egress.valid && !egress.ready;
      prev_word  = {egress.last, egress.data};
    end
    @(posedge clk);
    #1;
    if (rnd_rdy) egress.ready = ($urandom_range(0, 3) != 0);
  endtask

  // drop_k: 1-based word index at which the buffer is expected full (0 = none).
  task automatic send_pkt(input int len, input logic [31:0] base, input int drop_k, input int gap_max);
    logic [WIDTH:0] w;
    bit dropped;
    bit we_exp;
    dropped = (drop_k != 0) && (drop_k <= len);
    for (int k = 1; k <= len; k++) begin
      we_exp = !((drop_k != 0) && (k >= drop_k));
      w = {1'(k == len), base + 32'(k - 1)};
      ingress.valid = 1'b1;
      ingress.data  = w[WIDTH-1:0];
      ingress.last  = w[WIDTH];
      #1;
      chk("ram_we", 64'(ram_we), 64'(we_exp));
      if (we_exp) begin
        chk("ram_waddr", 64'(ram_waddress), 64'((wa_commit + k - 1) % WORDS));
        chk("ram_din", 64'(ram_din), 64'(w));
      end
      cyc();
      chk("drop_pulse", 64'(drop_pulse), 64'(k == drop_k));
      if (k < len && gap_max > 0) begin
        ingress.valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) cyc();
      end
    end
    ingress.valid = 1'b0;
    ingress.last  = 1'b0;
    if (dropped) drops++;
    else begin
      for (int k = 1; k <= len; k++) exp_q.push_back({1'(k == len), base + 32'(k - 1)});
      wa_commit = (wa_commit + len) % WORDS;
    end
  endtask

  task automatic drain(input string tag);
    int w = 0;
    egress.ready = 1'b1;
    while (rd_idx < exp_q.size() && w < 500) begin
      cyc();
      w++;
    end
    repeat (2) cyc();
    chk({tag, "_left"}, 64'(exp_q.size() - rd_idx), 64'(0));
    chk({tag, "_pkt_count"}, 64'(pkt_count), 64'(0));
    chk({tag, "_valid"}, 64'(egress.valid), 64'(1'b0));
  endtask

  initial begin
    ingress.valid = 1'b0;
    ingress.data  = '0;
    ingress.last  = 1'b0;
    egress.ready  = 1'b0;
    repeat (3) cyc();
    chk("rst_valid", 64'(egress.valid), 64'(1'b0));
    chk("rst_pkt_count", 64'(pkt_count), 64'(0));
    chk("rst_drop_count", 64'(drop_count), 64'(0));
    chk("rst_drop_pulse", 64'(drop_pulse), 64'(1'b0));
    chk("rst_ram_we", 64'(ram_we), 64'(1'b0));
    chk("rst_waddr", 64'(ram_waddress), 64'(0));
    chk("rst_raddr", 64'(ram_raddress), 64'(0));
    chk("in_ready", 64'(ingress.ready), 64'(1'b1));
    reset_n = 1'b1;
    cyc();

    // 4-word packet, egress open: first word two cycles after the last input.
    egress.ready = 1'b1;
    send_pkt(4, 32'hA0, 0, 0);
    #1;
    chk("t1_no_early", 64'(egress.valid), 64'(1'b0));
    chk("t1_pkt_count", 64'(pkt_count), 64'(1));
    for (int i = 0; i < 4; i++) begin
      cyc();
      #1;
      chk("t1_valid", 64'(egress.valid), 64'(1'b1));
      chk("t1_data", 64'(egress.data), 64'(32'hA0 + 32'(i)));
      chk("t1_last", 64'(egress.last), 64'(i == 3));
    end
    cyc();
    #1;
    chk("t1_pkt_done", 64'(pkt_count), 64'(0));

    // Single-word packet.
    send_pkt(1, 32'h55, 0, 0);
    #1;
    chk("t2_pkt_count", 64'(pkt_count), 64'(1));
    cyc();
    #1;
    chk("t2_word", 64'({egress.valid, egress.last, egress.data}), 64'({2'b11, 32'h55}));
    cyc();
    #1;
    chk("t2_pkt_done", 64'(pkt_count), 64'(0));

    // Oversized packet on an empty buffer: full at word WORDS+1.
    send_pkt(1201, $urandom, WORDS + 1, 0);
    chk("t3_drop_count", 64'(drop_count), 64'(drops));
    chk("t3_pkt_count", 64'(pkt_count), 64'(0));
    chk("t3_valid", 64'(egress.valid), 64'(1'b0));
    send_pkt(1, 32'h77, 0, 0);  // lands at the rewound commit point
    drain("t3");

    // 15 committed words with egress stalled; the skid pulls 2 out of RAM,
    // leaving room for 3 more words, so the 4th word of the next packet hits full.
    egress.ready = 1'b0;
    repeat (3) send_pkt(5, $urandom, 0, 0);
    repeat (3) cyc();
    chk("t4_valid", 64'(egress.valid), 64'(1'b1));
    chk("t4_pkt_count", 64'(pkt_count), 64'(pend_pkts()));
    send_pkt(4, $urandom, WORDS - (15 - 2) + 1, 0);
    chk("t4_drop_count", 64'(drop_count), 64'(drops));
    chk("t4_pkt_after", 64'(pkt_count), 64'(3));
    drain("t4");

    // Random packets, random egress backpressure, never enough to overflow.
    rnd_rdy = 1;
    for (int p = 0; p < 100; p++) begin
      int len = $urandom_range(1, 6);
      int w = 0;
      while ((exp_q.size() - rd_idx + len > WORDS) && w < 1000) begin
        cyc();
        w++;
      end
      send_pkt(len, $urandom, 0, 2);
      repeat ($urandom_range(0, 1)) cyc();
    end
    rnd_rdy = 0;
    drain("t5");
    chk("t5_drop_count", 64'(drop_count), 64'(drops));

    // Reset in the middle of a packet with two packets committed.
    egress.ready = 1'b0;
    send_pkt(3, $urandom, 0, 0);
    send_pkt(3, $urandom, 0, 0);
    ingress.valid = 1'b1;
    ingress.data  = 32'hDEAD;
    cyc();
    cyc();
    #1;
    chk("t6_pre_valid", 64'(egress.valid), 64'(1'b1));
    chk("t6_pre_pkt", 64'(pkt_count), 64'(pend_pkts()));
    reset_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(egress.valid), 64'(1'b0));
    ingress.valid = 1'b0;
    repeat (2) cyc();
    chk("t6_pkt_count", 64'(pkt_count), 64'(0));
    chk("t6_drop_count", 64'(drop_count), 64'(0));
    chk("t6_waddr", 64'(ram_waddress), 64'(0));
    chk("t6_raddr", 64'(ram_raddress), 64'(0));
    drops     = 0;
    wa_commit = 0;
    reset_n   = 1'b1;
    cyc();
    egress.ready = 1'b1;
    send_pkt(3, 32'hC0, 0, 0);
    send_pkt(2, 32'hD0, 0, 1);
    drain("t6");
    chk("t6_drops_after", 64'(drop_count), 64'(0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
